riscv32_mem_arb: RTL and testbench
==================================

RISCV32_MEM_ARB -- requirements
Module: riscv32_mem_arb

Interface
Parameters:
REQ-001 SHALL have parameter NUM_CH, default 2, number of requester channels (1..8; ch0 = instruction fetch, ch1 = data).
REQ-002 SHALL have parameter ADDR_W, default 8, word-address width; memory depth is 2^ADDR_W words.
REQ-003 SHALL have parameter DATA_W, default 32, word width, multiple of 8.
REQ-004 SHALL have parameter WAIT, default 0, access wait states (0..15).

Ports:
REQ-005 iCLK  in  1  clock; the block uses this single clock, and all state changes on its rising edge.
REQ-006 iRST  in  1  reset; synchronous, active-high.
REQ-007 iREQ  in  NUM_CH  per-channel request, level.
REQ-008 iWR  in  NUM_CH  per-channel write (1) / read (0).
REQ-009 iADDR  in  NUM_CH*ADDR_W  per-channel word address, channel k at slice k.
REQ-010 iWDATA  in  NUM_CH*DATA_W  per-channel write data.
REQ-011 iBE  in  NUM_CH*(DATA_W/8)  per-channel byte enables, bit b selects byte b.
REQ-012 oGNT  out  NUM_CH  one-hot grant pulse.
REQ-013 oACK  out  NUM_CH  one-hot completion pulse.
REQ-014 oRDATA  out  DATA_W  shared read data, valid only with a read oACK.
REQ-015 oBUSY  out  1  high while a transaction is outstanding.

Function
REQ-016 Internal storage SHALL be a 2^ADDR_W x DATA_W synchronous array; contents are undefined at power-up.
REQ-017 FSM SHALL have two states: IDLE and BUSY.
REQ-018 In IDLE with any iREQ high, at the edge the FSM SHALL select the winner, latch its iWR/iADDR/iWDATA/iBE, set oGNT[winner]=1 for exactly one cycle, load the wait counter with WAIT, and enter BUSY.
REQ-019 Arbitration SHALL be round-robin: the search starts at the channel after the last granted one and wraps from NUM_CH-1 to 0; after reset the search starts at ch0.
REQ-020 In BUSY with counter != 0, the counter SHALL decrement each edge; iREQ SHALL be ignored.
REQ-021 In BUSY with counter == 0, at the edge the FSM SHALL perform the access, pulse oACK[winner] for one cycle, and return to IDLE.
REQ-022 Latency: oACK SHALL be asserted WAIT+1 cycles after oGNT; with WAIT=0, oACK follows oGNT in the next cycle.
REQ-023 Write: only bytes with latched iBE bit set SHALL be updated; iBE=0 completes with oACK and no memory change.
REQ-024 Read: oRDATA SHALL present the full word at the latched address in the same cycle as oACK, and hold that value until the next read completes; writes SHALL NOT change oRDATA.
REQ-025 Requesters SHALL hold iREQ and the request fields stable until oGNT; fields may change after oGNT without affecting the transaction.
REQ-026 An iREQ still high in the cycle oACK is asserted SHALL be treated as a new request in the following IDLE cycle; minimum spacing between grants is WAIT+2 cycles.
REQ-027 Requests on a channel with oACK high in the same cycle SHALL compete normally under REQ-019.
REQ-028 oBUSY SHALL be high from the cycle oGNT is asserted through the cycle oACK is asserted.
REQ-029 oGNT and oACK SHALL never have more than one bit set, and SHALL never be simultaneously high.

Reset
REQ-030 While iRST is high at an edge, the FSM SHALL enter IDLE, and oGNT, oACK, oRDATA and oBUSY SHALL be 0. The round-robin pointer SHALL restart at ch0 and the wait counter SHALL be 0.
REQ-031 Reset during BUSY SHALL abort the transaction with no oACK; a pending write SHALL NOT be performed. Memory contents SHALL be retained across reset.

Verification
REQ-032 WAIT=0, ch1 write addr 0x10, data 0xDEADBEEF, iBE=4'hF, then a read of 0x10 -> oGNT[1] at cycle n, oACK[1] at n+1; the read returns oRDATA=0xDEADBEEF.
REQ-033 Byte enables: write 0x11223344 to 0x20 with iBE=4'hF, then write 0xAABBCCDD with iBE=4'b0101, then read 0x20 -> 0x11BB33DD.
REQ-034 WAIT=3: ch0 and ch1 request continuously from reset -> grants ch0, ch1, ch0, ch1 with grants 5 cycles apart; each oACK arrives 4 cycles after its oGNT, and oBUSY is high for 5 cycles per transaction.
REQ-035 NUM_CH=4, all channels request continuously -> grant order 0,1,2,3,0 (pointer wraps); with only ch2 requesting, ch2 is granted back-to-back every WAIT+2 cycles.
REQ-036 WAIT=5: assert iRST 2 cycles after oGNT of a write of 0x55 to 0x30 (previous value 0x0) -> no oACK, outputs 0; a subsequent read of 0x30 returns 0x0, and the next grant goes to ch0.
REQ-037 Address wrap: ADDR_W=8, write address 0xFF then read 0xFF and 0x00 -> distinct data returned, with no aliasing.

Source files
------------

// File: rtl/riscv32_mem_arb.sv
// Round-robin arbiter in front of a single-port word memory.
// One transaction is outstanding at a time: grant, WAIT wait states, then the
// access and a one-cycle completion pulse to the winning channel.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; the next edge grants the round-robin winner
// BUSY  | transaction latched; counting wait states, access at count 0
module riscv32_mem_arb #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int WAIT   = 0
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic [NUM_CH-1:0]            iREQ,
    input  logic [NUM_CH-1:0]            iWR,
    input  logic [NUM_CH*ADDR_W-1:0]     iADDR,
    input  logic [NUM_CH*DATA_W-1:0]     iWDATA,
    input  logic [NUM_CH*(DATA_W/8)-1:0] iBE,
    output logic [NUM_CH-1:0]            oGNT,
    output logic [NUM_CH-1:0]            oACK,
    output logic [DATA_W-1:0]            oRDATA,
    output logic                         oBUSY
);

    localparam int BYTES = DATA_W / 8;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WAIT_V = 4'(WAIT);
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    ptr, ptr_nxt;
    logic [PTR_W-1:0]    win, win_nxt;
    logic [PTR_W-1:0]    pick;
    logic                found;
    logic [3:0]          cnt, cnt_nxt;
    logic                wr_q, wr_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [DATA_W-1:0]   wdata_q, wdata_nxt;
    logic [BYTES-1:0]    be_q, be_nxt;
    logic [NUM_CH-1:0]   gnt_nxt, ack_nxt;
    logic                busy_nxt;
    logic                do_access;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Round-robin search: first requester at or after ptr, wrapping to ch0.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && iREQ[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    // Next-state, transaction latch and next output values.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        cnt_nxt   = cnt;
        wr_nxt    = wr_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        be_nxt    = be_q;
        gnt_nxt   = '0;
        ack_nxt   = '0;
        busy_nxt  = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt      = BUSY;
                    win_nxt        = pick;
                    ptr_nxt        = (pick == LAST_CH) ? '0 : pick + 1'b1;
                    cnt_nxt        = WAIT_V;
                    wr_nxt         = iWR[pick];
                    addr_nxt       = iADDR[int'(pick)*ADDR_W +: ADDR_W];
                    wdata_nxt      = iWDATA[int'(pick)*DATA_W +: DATA_W];
                    be_nxt         = iBE[int'(pick)*BYTES +: BYTES];
                    gnt_nxt[pick]  = 1'b1;
                    busy_nxt       = 1'b1;
                end
            end
            BUSY: begin
                busy_nxt = 1'b1;
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    do_access    = 1'b1;
                    ack_nxt[win] = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointer, latched request and registered output pulses.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            oGNT    <= '0;
            oACK    <= '0;
            oBUSY   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            win     <= win_nxt;
            cnt     <= cnt_nxt;
            wr_q    <= wr_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            be_q    <= be_nxt;
            oGNT    <= gnt_nxt;
            oACK    <= ack_nxt;
            oBUSY   <= busy_nxt;
        end
    end

    // Read data is captured only on a completing read and held until the next one.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oRDATA <= '0;
        end else if (do_access && !wr_q) begin
            oRDATA <= mem[addr_q];
        end
    end

    // Memory has no reset so contents survive iRST; a write aborted by reset is dropped.
    always_ff @(posedge iCLK) begin
        if (do_access && wr_q && !iRST) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_q[b]) mem[addr_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv32_mem_arb.sv
// Bench for riscv32_mem_arb: two instances (2 ch / WAIT=0 and 4 ch / WAIT=3)
// run in lockstep against a transaction-timeline reference model.
module tb_riscv32_mem_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_d   [2][4];
    logic        wr_d    [2][4];
    logic [7:0]  addr_d  [2][4];
    logic [31:0] wdata_d [2][4];
    logic [3:0]  be_d    [2][4];
    logic        pend    [2][4];
    int          mode    [2];

    logic [1:0]   req0, wr0, g0, a0;
    logic [15:0]  ad0;
    logic [63:0]  wd0;
    logic [7:0]   be0;
    logic [31:0]  r0;
    logic         b0;
    logic [3:0]   req1, wr1, g1, a1;
    logic [31:0]  ad1;
    logic [127:0] wd1;
    logic [15:0]  be1;
    logic [31:0]  r1;
    logic         b1;

    assign req0 = {req_d[0][1], req_d[0][0]};
    assign wr0  = {wr_d[0][1], wr_d[0][0]};
    assign ad0  = {addr_d[0][1], addr_d[0][0]};
    assign wd0  = {wdata_d[0][1], wdata_d[0][0]};
    assign be0  = {be_d[0][1], be_d[0][0]};
    assign req1 = {req_d[1][3], req_d[1][2], req_d[1][1], req_d[1][0]};
    assign wr1  = {wr_d[1][3], wr_d[1][2], wr_d[1][1], wr_d[1][0]};
    assign ad1  = {addr_d[1][3], addr_d[1][2], addr_d[1][1], addr_d[1][0]};
    assign wd1  = {wdata_d[1][3], wdata_d[1][2], wdata_d[1][1], wdata_d[1][0]};
    assign be1  = {be_d[1][3], be_d[1][2], be_d[1][1], be_d[1][0]};

    riscv32_mem_arb #(.NUM_CH(2), .ADDR_W(8), .DATA_W(32), .WAIT(0)) dut0 (
        .iCLK(clk), .iRST(rst), .iREQ(req0), .iWR(wr0), .iADDR(ad0), .iWDATA(wd0),
        .iBE(be0), .oGNT(g0), .oACK(a0), .oRDATA(r0), .oBUSY(b0));

    riscv32_mem_arb #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32), .WAIT(3)) dut1 (
        .iCLK(clk), .iRST(rst), .iREQ(req1), .iWR(wr1), .iADDR(ad1), .iWDATA(wd1),
        .iBE(be1), .oGNT(g1), .oACK(a1), .oRDATA(r1), .oBUSY(b1));

    // reference model state
    bit          active  [2];
    int          g_cyc   [2];
    int          last_ch [2];
    int          t_ch    [2];
    logic        t_wr    [2];
    logic [7:0]  t_addr  [2];
    logic [31:0] t_data  [2];
    logic [3:0]  t_be    [2];
    logic [31:0] mem_m   [2][256];
    logic [3:0]  kn_m    [2][256];
    logic [31:0] rd_exp  [2];
    logic [31:0] rd_msk  [2];
    logic [3:0]  exp_gnt [2];
    logic [3:0]  exp_ack [2];
    logic        exp_busy[2];

    int cyc = 0;
    int gq_ch[$];
    int gq_cyc[$];
    int n_chk = 0;
    int n_bad = 0;

    function automatic int nch(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int wt(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic logic [3:0] obs_gnt(input int i);
        return (i == 0) ? {2'b00, g0} : g1;
    endfunction

    function automatic logic [3:0] obs_ack(input int i);
        return (i == 0) ? {2'b00, a0} : a1;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Timeline model: a grant at cycle g completes at g+WAIT+1; a new grant
    // is possible only from an idle cycle; search starts after last winner.
    task automatic model_edge(input int i);
        bit found;
        int c;
        exp_gnt[i] = '0;
        exp_ack[i] = '0;
        found = 0;
        if (rst) begin
            active[i]  = 0;
            last_ch[i] = -1;
            rd_exp[i]  = '0;
            rd_msk[i]  = '1;
        end else if (active[i]) begin
            if (cyc == g_cyc[i] + wt(i) + 1) begin
                exp_ack[i][t_ch[i]] = 1'b1;
                active[i] = 0;
                if (t_wr[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (t_be[i][b]) begin
                            mem_m[i][t_addr[i]][b*8 +: 8] = t_data[i][b*8 +: 8];
                            kn_m[i][t_addr[i]][b] = 1'b1;
                        end
                    end
                end else begin
                    rd_exp[i] = mem_m[i][t_addr[i]];
                    for (int b = 0; b < 4; b++)
                        rd_msk[i][b*8 +: 8] = {8{kn_m[i][t_addr[i]][b]}};
                end
            end
        end else begin
            for (int off = 0; off < nch(i); off++) begin
                c = (last_ch[i] + 1 + off) % nch(i);
                if (!found && req_d[i][c]) begin
                    found      = 1;
                    active[i]  = 1;
                    g_cyc[i]   = cyc;
                    t_ch[i]    = c;
                    last_ch[i] = c;
                    t_wr[i]    = wr_d[i][c];
                    t_addr[i]  = addr_d[i][c];
                    t_data[i]  = wdata_d[i][c];
                    t_be[i]    = be_d[i][c];
                    exp_gnt[i][c] = 1'b1;
                end
            end
        end
        exp_busy[i] = active[i] || (exp_ack[i] != '0);
    endtask

    task automatic compare(input int i);
        logic [31:0] ro;
        logic        bo;
        ro = (i == 0) ? r0 : r1;
        bo = (i == 0) ? b0 : b1;
        check_val($sformatf("i%0d_gnt", i), 64'(obs_gnt(i)), 64'(exp_gnt[i]));
        check_val($sformatf("i%0d_ack", i), 64'(obs_ack(i)), 64'(exp_ack[i]));
        check_val($sformatf("i%0d_busy", i), 64'(bo), 64'(exp_busy[i]));
        check_val($sformatf("i%0d_rdata", i), 64'(ro & rd_msk[i]), 64'(rd_exp[i] & rd_msk[i]));
    endtask

    task automatic drive(input int i);
        logic [4:0] r;
        for (int k = 0; k < nch(i); k++) begin
            if (exp_gnt[i][k]) pend[i][k] = 1'b0;
            if (mode[i] == 0) begin
                if (!pend[i][k]) req_d[i][k] = 1'b0;
            end else if (mode[i] == 1) begin
                if (!pend[i][k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        r = 5'($urandom_range(0, 31));
                        req_d[i][k]   = 1'b1;
                        pend[i][k]    = 1'b1;
                        wr_d[i][k]    = 1'($urandom_range(0, 1));
                        addr_d[i][k]  = {(r[4] ? 4'hF : 4'h0), r[3:0]};
                        wdata_d[i][k] = $urandom;
                        be_d[i][k]    = 4'($urandom_range(0, 15));
                    end else begin
                        req_d[i][k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        logic [3:0] og;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) model_edge(i);
        for (int i = 0; i < 2; i++) compare(i);
        og = obs_gnt(1);
        for (int k = 0; k < 4; k++) begin
            if (og[k]) begin
                gq_ch.push_back(k);
                gq_cyc.push_back(cyc);
            end
        end
        for (int i = 0; i < 2; i++) drive(i);
    endtask

    task automatic set_req(input int i, input int k, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        req_d[i][k]   = 1'b1;
        pend[i][k]    = 1'b1;
        wr_d[i][k]    = w;
        addr_d[i][k]  = a;
        wdata_d[i][k] = d;
        be_d[i][k]    = be;
    endtask

    // Issue one directed transaction; lat is the observed oACK-oGNT distance.
    task automatic txn(input int i, input int k, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be, output int lat);
        int  gc;
        bit  done;
        logic [3:0] og, oa;
        gc = -1;
        lat = -1;
        done = 0;
        mode[i] = 0;
        set_req(i, k, w, a, d, be);
        for (int n = 0; n < 60 && !done; n++) begin
            step();
            og = obs_gnt(i);
            oa = obs_ack(i);
            if (og[k]) gc = cyc;
            if (oa[k] && gc >= 0) lat = cyc - gc;
            if (exp_ack[i][k]) done = 1;
        end
        if (!done) check_val("txn_timeout", 64'd0, 64'd1);
    endtask

    int lat;

    initial begin
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0;
            active[i] = 0;
            last_ch[i] = -1;
            rd_exp[i] = '0;
            rd_msk[i] = '1;
            for (int k = 0; k < 4; k++) begin
                req_d[i][k] = 0; wr_d[i][k] = 0; addr_d[i][k] = 0;
                wdata_d[i][k] = 0; be_d[i][k] = 0; pend[i][k] = 0;
            end
            for (int a = 0; a < 256; a++) begin
                mem_m[i][a] = '0;
                kn_m[i][a] = '0;
            end
        end

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // write/read latency and data, WAIT=0
        txn(0, 1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, lat);
        check_val("wr_latency", 64'(lat), 64'd1);
        txn(0, 1, 1'b0, 8'h10, 32'h0, 4'hF, lat);
        check_val("rd_latency", 64'(lat), 64'd1);
        check_val("rd_10", 64'(r0), 64'h DEADBEEF);

        // byte-enable merge, then a write must not disturb held read data
        txn(0, 0, 1'b1, 8'h20, 32'h11223344, 4'hF, lat);
        txn(0, 0, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, lat);
        txn(0, 0, 1'b0, 8'h20, 32'h0, 4'h0, lat);
        check_val("be_merge", 64'(r0), 64'h11BB33DD);
        txn(0, 1, 1'b1, 8'h20, 32'h0, 4'h0, lat);
        txn(0, 1, 1'b1, 8'h21, 32'h01020304, 4'hF, lat);
        check_val("rd_hold", 64'(r0), 64'h11BB33DD);
        txn(0, 0, 1'b0, 8'h20, 32'h0, 4'hF, lat);
        check_val("be_zero_nochange", 64'(r0), 64'h11BB33DD);

        // address extremes do not alias
        txn(0, 0, 1'b1, 8'hFF, 32'hCAFE0001, 4'hF, lat);
        txn(0, 1, 1'b1, 8'h00, 32'hCAFE0002, 4'hF, lat);
        txn(0, 0, 1'b0, 8'hFF, 32'h0, 4'hF, lat);
        check_val("rd_ff", 64'(r0), 64'hCAFE0001);
        txn(0, 1, 1'b0, 8'h00, 32'h0, 4'hF, lat);
        check_val("rd_00", 64'(r0), 64'hCAFE0002);

        // WAIT=3, ch0+ch1 continuous from reset
        mode[1] = 2;
        set_req(1, 0, 1'b0, 8'h40, 32'h0, 4'hF);
        set_req(1, 1, 1'b0, 8'h41, 32'h0, 4'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        gq_ch.delete();
        gq_cyc.delete();
        repeat (22) step();
        check_val("rr2_count", 64'(gq_ch.size() >= 4), 64'd1);
        if (gq_ch.size() >= 4) begin
            for (int j = 0; j < 4; j++) check_val("rr2_order", 64'(gq_ch[j]), 64'(j % 2));
            for (int j = 0; j < 3; j++) check_val("rr2_space", 64'(gq_cyc[j+1] - gq_cyc[j]), 64'd5);
        end

        // four channels continuous, pointer wraps
        set_req(1, 2, 1'b0, 8'h42, 32'h0, 4'hF);
        set_req(1, 3, 1'b0, 8'h43, 32'h0, 4'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        gq_ch.delete();
        gq_cyc.delete();
        repeat (26) step();
        check_val("rr4_count", 64'(gq_ch.size() >= 5), 64'd1);
        if (gq_ch.size() >= 5)
            for (int j = 0; j < 5; j++) check_val("rr4_order", 64'(gq_ch[j]), 64'(j % 4));

        // only ch2 requesting: back-to-back every WAIT+2 cycles
        req_d[1][0] = 0; req_d[1][1] = 0; req_d[1][3] = 0;
        pend[1][0] = 0; pend[1][1] = 0; pend[1][3] = 0;
        gq_ch.delete();
        gq_cyc.delete();
        repeat (24) step();
        check_val("solo_count", 64'(gq_ch.size() >= 3), 64'd1);
        for (int j = 0; j < gq_ch.size(); j++) check_val("solo_ch", 64'(gq_ch[j]), 64'd2);
        for (int j = 0; j + 1 < gq_ch.size(); j++)
            check_val("solo_space", 64'(gq_cyc[j+1] - gq_cyc[j]), 64'd5);
        mode[1] = 0;
        req_d[1][2] = 0;
        pend[1][2] = 0;
        repeat (8) step();

        // reset mid-write aborts the write; next grant goes to ch0
        txn(1, 1, 1'b1, 8'h30, 32'h0, 4'hF, lat);
        check_val("w3_latency", 64'(lat), 64'd4);
        begin
            bit got;
            got = 0;
            set_req(1, 1, 1'b1, 8'h30, 32'h55, 4'hF);
            for (int n = 0; n < 20 && !got; n++) begin
                step();
                if (exp_gnt[1][1]) got = 1;
            end
            check_val("abort_gnt_seen", 64'(got), 64'd1);
        end
        step();
        step();
        rst = 1'b1;
        step();
        check_val("rst_gnt", 64'(g1), 64'd0);
        check_val("rst_ack", 64'(a1), 64'd0);
        check_val("rst_busy", 64'(b1), 64'd0);
        check_val("rst_rdata", 64'(r1), 64'd0);
        rst = 1'b0;
        repeat (6) step();
        gq_ch.delete();
        gq_cyc.delete();
        set_req(1, 1, 1'b0, 8'h31, 32'h0, 4'hF);
        txn(1, 0, 1'b0, 8'h30, 32'h0, 4'hF, lat);
        check_val("post_rst_first", 64'(gq_ch.size() > 0 ? gq_ch[0] : -1), 64'd0);
        check_val("aborted_write", 64'(r1), 64'd0);
        repeat (10) step();

        // randomized traffic with occasional reset
        mode[0] = 1;
        mode[1] = 1;
        repeat (3000) begin
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end
        mode[0] = 0;
        mode[1] = 0;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
